// File: rtl/tpu_ctrl_nxn.sv
// tpu_ctrl_nxn: load/compute/hold sequencer for an NxN systolic matrix unit.
// Decodes load/output instructions, tracks distinct A/B writes and times the MMU window.
module tpu_ctrl_nxn #(
   parameter int N            = 2,
   parameter bit KEEP_WEIGHTS = 1'b0,
   localparam int AW  = $clog2(N*N),
   localparam int IW  = 2*AW+4,
   localparam int CYC = 3*N-1,
   localparam int CW  = $clog2(CYC)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [IW-1:0] instrn,
   output logic          mem_load_mat,
   output logic [AW:0]   mem_addr,
   output logic          mmu_en,
   output logic [CW-1:0] mmu_cycle,
   output logic          mmu_clear,
   output logic [AW-1:0] output_select,
   output logic          out_valid,
   output logic          busy,
   output logic          done,
   output logic          load_err
);

   localparam int NN = N*N;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_LAUNCH,
      S_COMPUTE,
      S_HOLD
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [NN-1:0]   r_a_ld, r_b_ld, w_a_nxt, w_b_nxt, w_bit;
   logic [CW-1:0]   r_cyc;
   logic            r_ld, r_done, r_err;
   logic [AW:0]     r_addr;
   logic [AW-1:0]   r_osel;

   logic            w_load_en, w_sel, w_out_en, w_idx_ok, w_busy_st, w_valid, w_done_nxt;
   logic [AW-1:0]   w_idx, w_osel;
   logic            w_unused_rsvd;

   assign w_load_en     = instrn[0];
   assign w_sel         = instrn[1];
   assign w_idx         = instrn[AW+1:2];
   assign w_out_en      = instrn[AW+2];
   assign w_osel        = instrn[2*AW+2:AW+3];
   assign w_unused_rsvd = instrn[IW-1];

   assign w_idx_ok  = ({1'b0, w_idx} < (AW+1)'(NN));
   assign w_busy_st = (r_state == S_LAUNCH) || (r_state == S_COMPUTE);
   assign w_valid   = w_load_en && w_idx_ok && !w_busy_st;
   assign w_bit     = w_valid ? (NN'(1) << w_idx) : '0;

   // Bitmaps are cleared first when leaving HOLD so the new write still counts.
   always_comb begin
      w_a_nxt     = r_a_ld;
      w_b_nxt     = r_b_ld;
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      if (r_state == S_HOLD && w_valid) begin
         w_b_nxt = '0;
         if (!KEEP_WEIGHTS) w_a_nxt = '0;
      end
      if (w_sel) w_b_nxt = w_b_nxt | w_bit;
      else       w_a_nxt = w_a_nxt | w_bit;

      case (r_state)
         S_IDLE:    if (w_valid) w_state_nxt = S_LOAD;
         S_LOAD:    if (w_valid && (&{w_a_nxt, w_b_nxt})) w_state_nxt = S_LAUNCH;
         S_LAUNCH:  w_state_nxt = S_COMPUTE;
         S_COMPUTE: begin
            if (r_cyc == CW'(CYC-1)) begin
               w_state_nxt = S_HOLD;
               w_done_nxt  = 1'b1;
            end
         end
         S_HOLD:    if (w_valid) w_state_nxt = S_LOAD;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a_ld  <= '0;
         r_b_ld  <= '0;
         r_cyc   <= '0;
         r_ld    <= 1'b0;
         r_addr  <= '0;
         r_err   <= 1'b0;
         r_osel  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_a_ld  <= w_a_nxt;
         r_b_ld  <= w_b_nxt;
         r_cyc   <= (r_state == S_COMPUTE && w_state_nxt == S_COMPUTE) ? r_cyc + 1'b1 : '0;
         r_ld    <= w_valid;
         r_addr  <= w_valid ? {w_sel, w_idx} : '0;
         r_err   <= w_load_en && !w_valid;
         r_done  <= w_done_nxt;
         if (w_out_en) r_osel <= w_osel;
      end
   end

   assign mem_load_mat  = r_ld;
   assign mem_addr      = r_addr;
   assign mmu_en        = (r_state == S_COMPUTE);
   assign mmu_cycle     = r_cyc;
   assign mmu_clear     = (r_state == S_COMPUTE) && (r_cyc == '0);
   assign output_select = r_osel;
   assign out_valid     = (r_state == S_HOLD);
   assign busy          = w_busy_st;
   assign done          = r_done;
   assign load_err      = r_err;

endmodule

// File: doc/tpu_ctrl_nxn.md
Name: tpu_ctrl_nxn

Overview:
- Parametrised control FSM for an NxN systolic matrix unit.
- Decodes per-cycle load/output instructions into memory write strobes and addresses.
- Tracks which distinct A (weight) and B (input) elements have been written, launches and times the MMU compute window, and holds results valid until the next load.
- Adds an optional weight-stationary mode in which A is kept across jobs so only B needs reloading.

Parameters:
- N, 2, matrix dimension (2..4); derived AW = clog2(N*N), IW = 2*AW+4, CYC = 3*N-1, CW = clog2(CYC)
- KEEP_WEIGHTS, 0, 1 = A-loaded bitmap survives HOLD->LOAD, so only the N*N B elements are required for the next job

Ports:
- clk  in  1  clock
- rst  in  1  reset
- instrn  in  IW  [0] load_en, [1] sel (0=A, 1=B), [AW+1:2] elem index, [AW+2] output_en, [2AW+2:AW+3] output elem sel, [IW-1] reserved/ignored
- mem_load_mat  out  1  registered memory write strobe
- mem_addr  out  AW+1  registered {sel, index}
- mmu_en  out  1  MMU feed/compute enable
- mmu_cycle  out  CW  compute cycle index 0..CYC-1
- mmu_clear  out  1  1-cycle accumulator clear at compute start
- output_select  out  AW  registered output element select
- out_valid  out  1  results valid (HOLD)
- busy  out  1  high in LAUNCH or COMPUTE
- done  out  1  1-cycle pulse on entry to HOLD
- load_err  out  1  1-cycle pulse for a rejected load

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset, all outputs = 0, state = IDLE, both bitmaps (a_ld[N*N], b_ld[N*N]) cleared. Reset mid-job aborts with no further strobes.
- Valid load: load_en=1, index < N*N, state in {IDLE, LOAD, HOLD}.
  - Next edge: mem_load_mat=1, mem_addr={sel, index}, bitmap bit set.
  - Otherwise mem_load_mat=0 and mem_addr=0.
- Invalid index (>= N*N, possible for N=3): no write; load_err=1 for one cycle; bitmap unchanged.
- Load while busy (LAUNCH/COMPUTE): ignored; load_err=1 for one cycle; no mem strobe.
- Duplicate element: rewrite is performed (mem strobe issued); bitmap already set, so it does not advance completion.
- output_select: loads instrn output-sel field on any edge where output_en=1, in any state; otherwise holds.
- IDLE: valid load -> LOAD.
- LOAD: "full" = all a_ld and b_ld bits set, including the write captured this edge. When full -> LAUNCH, so the final mem strobe and LAUNCH entry occur on the same edge.
- LAUNCH (1 cycle): mmu_en=0, lets the final memory write land. -> COMPUTE.
- COMPUTE:
  - First cycle: mmu_en=1, mmu_cycle=0, mmu_clear=1. mmu_clear is 0 on all other cycles.
  - mmu_cycle increments each cycle.
  - In the cycle with mmu_cycle=CYC-1 -> HOLD.
  - Exactly CYC cycles with mmu_en=1.
- HOLD:
  - mmu_en=0, mmu_cycle=0, out_valid=1, done=1 on the first cycle only.
  - Remains in HOLD until a valid load, then -> LOAD.
  - On that edge b_ld is cleared; a_ld is cleared if KEEP_WEIGHTS=0, else retained. The new bit is then set. out_valid drops on the same edge.
- KEEP_WEIGHTS=1 with A retained: LOAD may become full after N*N B writes only.
  - If the load leaving HOLD is itself the last required element (N=1 is not supported, so this cannot occur for N>=2), the LOAD full rule still applies.
- Simultaneous load and output_en in one instrn: both are honoured.

Test Plan:
- N=2, reset, then 8 loads (A0..A3, B0..B3) on consecutive cycles:
  - mem_load_mat high for 8 cycles, addr 0..3 then 4..7.
  - LAUNCH follows the 8th strobe; mmu_en high exactly 5 cycles, mmu_cycle 0..4, mmu_clear only with cycle 0.
  - Then done pulse and out_valid=1.
- N=2, write A2 twice among 9 loads: compute starts only after all 8 distinct elements are present, not after 8 strobes.
- N=2, issue a load during COMPUTE cycle 2: load_err pulse, no mem strobe, mmu_cycle sequence uninterrupted.
- N=3, load index 10: load_err, no strobe. Full 18-element job gives mmu_en for 8 cycles.
- N=2, KEEP_WEIGHTS=1, second job loads only B0..B3 from HOLD: compute launches after the 4th B write. Same case with KEEP_WEIGHTS=0: stays in LOAD.
- Assert rst at COMPUTE cycle 1: all outputs 0 immediately; a subsequent job requires all 8 elements.
